// File: rtl/cache_arbiter_if.sv
// Two-requester / single-cache bus bundle for cache_arbiter.
// slave = arbiter view, master = requesters plus cache environment.
interface cache_arbiter_if;
   logic        req0, req1;
   logic [31:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic [3:0]  we0, we1;
   logic        ack0, ack1;
   logic [31:0] rdata0, rdata1;
   logic        err0, err1;
   logic [31:0] cache_address;
   logic [31:0] cache_data_in;
   logic [3:0]  cache_write_enable;
   logic [31:0] cache_data_out;
   logic        cache_data_out_ready;
   logic        cache_busy;

   modport slave (
      input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
      output ack0, ack1, rdata0, rdata1, err0, err1,
      output cache_address, cache_data_in, cache_write_enable,
      input  cache_data_out, cache_data_out_ready, cache_busy
   );

   modport master (
      output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
      input  ack0, ack1, rdata0, rdata1, err0, err1,
      input  cache_address, cache_data_in, cache_write_enable,
      output cache_data_out, cache_data_out_ready, cache_busy
   );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter of two requesters onto one cache port; req->ack in 3 cycles minimum.
// Holds off while cache_busy is high in IDLE; a stuck cache is aborted after TIMEOUT_CYCLES with err.
module cache_arbiter #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic          clk,
   input logic          rst,
   cache_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       we_q, we_d;
   logic             ack0_q, ack0_d, ack1_q, ack1_d;
   logic             err0_q, err0_d, err1_q, err1_d;
   logic [31:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic             pick;
   logic             done_ok;
   logic             timed_out;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      done_ok      = 1'b0;
      timed_out    = 1'b0;

      // On a tie the port that did not win last time takes the grant.
      if (bus.req0 && bus.req1) pick = ~last_grant_q;
      else                      pick = bus.req1;

      case (state_q)
         IDLE: begin
            if ((bus.req0 || bus.req1) && !bus.cache_busy) begin
               grant_d      = pick;
               last_grant_d = pick;
               addr_d       = pick ? bus.addr1  : bus.addr0;
               wdata_d      = pick ? bus.wdata1 : bus.wdata0;
               we_d         = pick ? bus.we1    : bus.we0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            done_ok   = (we_q != 4'd0) ? !bus.cache_busy
                                       : (bus.cache_data_out_ready && !bus.cache_busy);
            timed_out = !done_ok && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
            if (done_ok || timed_out) begin
               state_d = DONE;
               we_d    = 4'd0;
               if (grant_q) begin
                  ack1_d = 1'b1;
                  err1_d = timed_out;
                  if (timed_out)         rdata1_d = 32'd0;
                  else if (we_q == 4'd0) rdata1_d = bus.cache_data_out;
               end else begin
                  ack0_d = 1'b1;
                  err0_d = timed_out;
                  if (timed_out)         rdata0_d = 32'd0;
                  else if (we_q == 4'd0) rdata0_d = bus.cache_data_out;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         we_q         <= 4'd0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         rdata0_q     <= 32'd0;
         rdata1_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign bus.ack0               = ack0_q;
   assign bus.ack1               = ack1_q;
   assign bus.err0               = err0_q;
   assign bus.err1               = err1_q;
   assign bus.rdata0             = rdata0_q;
   assign bus.rdata1             = rdata1_q;
   assign bus.cache_address      = addr_q;
   assign bus.cache_data_in      = wdata_q;
   assign bus.cache_write_enable = we_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// Table-driven bench for cache_arbiter with a completion scoreboard and hand-written corner sequences.
module tb_cache_arbiter;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_arbiter_if ifc();
   cache_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(ifc));

   typedef struct {
      bit          port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      int          pre_busy;
      int          busy_cycles;
      logic [31:0] rd_data;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Scoreboard: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ifc.ack0 || ifc.ack1) begin
         chk("ack_exclusive", {31'd0, ifc.ack0 & ifc.ack1}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected none", ifc.ack0, ifc.ack1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ack_port", {31'd0, ifc.ack1}, {31'd0, mon_e.port});
            chk("rdata", mon_e.port ? ifc.rdata1 : ifc.rdata0, mon_e.rdata);
            chk("err", {31'd0, mon_e.port ? ifc.err1 : ifc.err0}, {31'd0, mon_e.err});
            chk("err_other", {31'd0, mon_e.port ? ifc.err0 : ifc.err1}, 32'd0);
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_ack0"},  {31'd0, ifc.ack0}, 32'd0);
      chk({tag, "_ack1"},  {31'd0, ifc.ack1}, 32'd0);
      chk({tag, "_err0"},  {31'd0, ifc.err0}, 32'd0);
      chk({tag, "_err1"},  {31'd0, ifc.err1}, 32'd0);
      chk({tag, "_rdata0"}, ifc.rdata0, 32'd0);
      chk({tag, "_rdata1"}, ifc.rdata1, 32'd0);
      chk({tag, "_caddr"},  ifc.cache_address, 32'd0);
      chk({tag, "_cdin"},   ifc.cache_data_in, 32'd0);
      chk({tag, "_cwe"},    {28'd0, ifc.cache_write_enable}, 32'd0);
   endtask

   // Drives one request and emulates the cache around it; the cache response is
   // scheduled by WAIT-cycle index k = n-2, where n counts edges since the sampling edge.
   task automatic run_txn(input vec_t v, input string tag);
      int   n;
      bit   bad;
      exp_t e;
      @(posedge clk); #1;
      if (v.port) begin
         ifc.req1 = 1'b1; ifc.addr1 = v.addr; ifc.wdata1 = v.wdata; ifc.we1 = v.we;
      end else begin
         ifc.req0 = 1'b1; ifc.addr0 = v.addr; ifc.wdata0 = v.wdata; ifc.we0 = v.we;
      end
      ifc.cache_busy           = (v.pre_busy > 0);
      ifc.cache_data_out_ready = 1'b0;
      ifc.cache_data_out       = v.rd_data;
      repeat (v.pre_busy) begin
         @(posedge clk); #1;
      end
      ifc.cache_busy = 1'b0;
      e.port  = v.port;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      exp_q.push_back(e);
      n   = 0;
      bad = 1'b0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (ifc.ack0 || ifc.ack1) break;
         if (ifc.cache_address !== v.addr || ifc.cache_write_enable !== v.we ||
             ifc.cache_data_in !== v.wdata) bad = 1'b1;
         if (n >= 2) begin
            ifc.cache_busy           = ((n - 2) < v.busy_cycles);
            ifc.cache_data_out_ready = (v.we == 4'd0) && ((n - 2) >= v.busy_cycles);
         end else begin
            ifc.cache_busy = (v.busy_cycles > 0);
         end
      end
      chk({tag, "_latency"}, n, v.exp_lat);
      chk({tag, "_bus_held"}, {31'd0, bad}, 32'd0);
      if (n < 40) chk({tag, "_we_in_done"}, {28'd0, ifc.cache_write_enable}, 32'd0);
      ifc.req0 = 1'b0;
      ifc.req1 = 1'b0;
      ifc.cache_busy = 1'b0;
      ifc.cache_data_out_ready = 1'b0;
   endtask

   initial begin
      int   acks;
      int   n;
      vec_t post;

      ifc.req0 = 1'b0; ifc.req1 = 1'b0;
      ifc.addr0 = 32'd0; ifc.addr1 = 32'd0;
      ifc.wdata0 = 32'd0; ifc.wdata1 = 32'd0;
      ifc.we0 = 4'd0; ifc.we1 = 4'd0;
      ifc.cache_data_out = 32'd0;
      ifc.cache_data_out_ready = 1'b0;
      ifc.cache_busy = 1'b0;

      //            port addr          wdata         we     pre busy rd_data       exp_rdata     err lat
      tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0,  0,  0, 32'h3431_3233, 32'h3431_3233, 1'b0, 3};
      tbl[1] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF,  0,  5, 32'h0000_0000, 32'h0000_0000, 1'b0, 8};
      tbl[2] = '{1'b1, 32'h0000_0200, 32'h0000_0000, 4'h0,  0,  2, 32'h1122_3344, 32'h1122_3344, 1'b0, 5};
      tbl[3] = '{1'b0, 32'h0000_0040, 32'h0A0B_0C0D, 4'h3,  0,  0, 32'h9999_9999, 32'h3431_3233, 1'b0, 3};
      tbl[4] = '{1'b1, 32'h0000_0204, 32'h0000_0000, 4'h0,  0, 99, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 18};
      tbl[5] = '{1'b0, 32'h0000_0080, 32'h0000_0000, 4'h0,  3,  1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4};
      tbl[6] = '{1'b0, 32'h0000_0084, 32'h1234_5678, 4'h8,  0, 99, 32'h0000_0000, 32'h0000_0000, 1'b1, 18};
      tbl[7] = '{1'b1, 32'h0000_0108, 32'h55AA_55AA, 4'h6,  0,  1, 32'h7777_7777, 32'h0000_0000, 1'b0, 4};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Reset in the third WAIT cycle abandons the transaction without an ack.
      @(posedge clk); #1;
      ifc.req0 = 1'b1; ifc.addr0 = 32'h0000_0300; ifc.we0 = 4'd0; ifc.wdata0 = 32'd0;
      ifc.cache_busy = 1'b0;
      @(posedge clk); #1;
      chk("rst_seq_issue_addr", ifc.cache_address, 32'h0000_0300);
      ifc.cache_busy = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset("wait_rst");
      rst = 1'b0;
      ifc.req0 = 1'b0;
      ifc.cache_busy = 1'b0;
      repeat (4) @(posedge clk);
      post = '{1'b0, 32'h0000_0310, 32'h0000_0000, 4'h0, 0, 0, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0, 3};
      run_txn(post, "post_rst");

      // Both requesters held after reset: grants alternate starting with port 0.
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ifc.req0 = 1'b1; ifc.addr0 = 32'h0000_0010; ifc.we0 = 4'd0; ifc.wdata0 = 32'd0;
      ifc.req1 = 1'b1; ifc.addr1 = 32'h0000_0020; ifc.we1 = 4'd0; ifc.wdata1 = 32'd0;
      ifc.cache_busy = 1'b0;
      ifc.cache_data_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.port  = k[0];
         e.rdata = k[0] ? 32'h0020_BEEF : 32'h0010_BEEF;
         e.err   = 1'b0;
         exp_q.push_back(e);
      end
      acks = 0;
      n    = 0;
      while (acks < 4 && n < 60) begin
         ifc.cache_data_out = {ifc.cache_address[15:0], 16'hBEEF};
         @(posedge clk); #1;
         n++;
         if (ifc.ack0 || ifc.ack1) acks++;
      end
      ifc.req0 = 1'b0;
      ifc.req1 = 1'b0;
      ifc.cache_data_out_ready = 1'b0;
      chk("rr_ack_count", acks, 32'd4);
      repeat (4) @(posedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
